seq_divider_16bit: RTL and testbench

Multi-cycle 16-bit restoring divider for the RISC datapath's ALU, the inverse of the 16-bit carry-lookahead adder. Accepts a dividend/divisor pair on a start pulse, produces one quotient bit per clock using trial subtraction through a `CLA_16bit_LCU` instance, and then presents quotient and remainder with a one-cycle done pulse. It sits beside the combinational adder in the execute stage; the control unit stalls on `busy`.

---
 rtl/seq_divider_16bit.sv | 217 +++++++++++++++++++++
 tb/tb_seq_divider_16bit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_16bit.sv
// seq_divider_16bit: multi-cycle 16-bit restoring divider.
// One quotient bit per clock. The trial subtraction uses a 16-bit
// carry-lookahead adder (CLA_16bit_LCU).
// Optional feature macro: SIGNED_DIV_EN adds a sign_mode port and
// two's-complement division. Magnitudes are divided, and the signs
// are fixed up when the result is registered.

// 4-bit CLA slice: local lookahead, plus group generate/propagate for the LCU.
module cla4_lane (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       gg,
  output logic       gp
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries inside the slice.
  always_comb begin
    c[0] = cin;
    for (int k = 0; k < 4; k++) c[k+1] = g[k] | (p[k] & c[k]);
  end

  assign sum = p ^ c[3:0];
  assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp  = &p;
endmodule

// 16-bit adder: four CLA slices, with a lookahead carry unit across the slices.
module CLA_16bit_LCU #(
  parameter int NUM_LANES = 4,
  parameter int VEC_W     = 4
) (
  input  logic [NUM_LANES*VEC_W-1:0] a,
  input  logic [NUM_LANES*VEC_W-1:0] b,
  input  logic                       cin,
  output logic [NUM_LANES*VEC_W-1:0] sum,
  output logic                       cout
);
  logic [NUM_LANES-1:0][VEC_W-1:0] a_l, b_l, s_l;
  logic [NUM_LANES-1:0]            gg, gp;
  logic [NUM_LANES:0]              gc;

  assign a_l = a;
  assign b_l = b;
  assign sum = s_l;

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      cla4_lane u_lane (
        .a   (a_l[i]),
        .b   (b_l[i]),
        .cin (gc[i]),
        .sum (s_l[i]),
        .gg  (gg[i]),
        .gp  (gp[i])
      );
    end
  endgenerate

  // Group carries, fully expanded so that no carry ripples between slices.
  always_comb begin
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
  end

  assign cout = gc[NUM_LANES];
endmodule

module seq_divider_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
  input  logic             sign_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] r, q, d;
  logic [4:0]       count;
  logic             accept, last_iter, dvs_zero;

  // Trial subtraction datapath.
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] diff, r_nxt, q_nxt, q_fin, r_fin;
  logic             cout, take;

  // Operand magnitudes and result sign flags.
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             neg_q_in, neg_r_in;

  assign accept    = start & (state != RUN);
  assign last_iter = (state == RUN) & (count == 5'd15);
  assign dvs_zero  = (divisor == '0);

`ifdef SIGNED_DIV_EN
  logic neg_q, neg_r;
  // The magnitude of -32768 is 16'h8000, which is still correct as an unsigned number.
  assign neg_r_in = sign_mode & dividend[WIDTH-1];
  assign neg_q_in = sign_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
  assign dvd_mag  = (sign_mode & dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag  = (sign_mode & divisor[WIDTH-1])  ? -divisor  : divisor;
  assign q_fin    = neg_q ? -q_nxt : q_nxt;
  assign r_fin    = neg_r ? -r_nxt : r_nxt;

  // Sign flags are latched with the operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= neg_q_in;
      neg_r <= neg_r_in;
    end
  end
`else
  assign neg_r_in = 1'b0;
  assign neg_q_in = 1'b0;
  assign dvd_mag  = dividend;
  assign dvs_mag  = divisor;
  assign q_fin    = q_nxt;
  assign r_fin    = r_nxt;
`endif

  // Shift in the next dividend bit, then subtract the divisor with A + ~B + 1.
  assign s = {r, q[WIDTH-1]};

  CLA_16bit_LCU u_cla (
    .a    (s[WIDTH-1:0]),
    .b    (~d),
    .cin  (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  // When s[16] is set, S is at least 2^16 and is always >= D; the wrapped difference is still exact.
  assign take  = s[WIDTH] | cout;
  assign r_nxt = take ? diff : s[WIDTH-1:0];
  assign q_nxt = {q[WIDTH-2:0], take};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: a zero divisor goes straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = dvs_zero ? DONE : RUN;
      RUN:     if (count == 5'd15) state_nxt = DONE;
      DONE:    state_nxt = start ? (dvs_zero ? DONE : RUN) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Working registers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      r           <= '0;
      q           <= dvd_mag;
      d           <= dvs_mag;
      count       <= '0;
      div_by_zero <= 1'b0;
      if (dvs_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      r     <= r_nxt;
      q     <= q_nxt;
      count <= count + 5'd1;
      if (last_iter) begin
        quotient  <= q_fin;
        remainder <= r_fin;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider_16bit.sv
// tb_seq_divider_16bit: the driver pushes expected results into a scoreboard,
// and a monitor pops and compares them on every done pulse.
// Also checks reset, busy timing, ignored mid-run starts and result holding.
// Build with +define+SIGNED_DIV_EN to cover signed division.
`timescale 1ns/1ps
module tb_seq_divider_16bit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic        sign_mode = 1'b0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  int total = 0, bad = 0, cyc = 0;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  seq_divider_16bit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef SIGNED_DIV_EN
    .sign_mode  (sign_mode),
`endif
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: plain integer division.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sm);
    exp_t e;
    int sa, sb_i;
    e.dbz = 1'b0;
    if (b == 16'd0) begin
      e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1;
    end else if (sm) begin
      sa = $signed(a); sb_i = $signed(b);
      e.q = 16'(sa / sb_i);
      e.r = 16'(sa % sb_i);
    end else begin
      e.q = a / b; e.r = a % b;
    end
    e.cyc = 0;
    return e;
  endfunction

  // Must be called just after a negedge, in IDLE or DONE. Returns 1ns after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sm);
    exp_t e;
    e = model(a, b, sm);
    e.cyc = cyc + ((b == 16'd0) ? 1 : 17);
    sb.push_back(e);
    dividend = a; divisor = b; sign_mode = sm; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Returns at the negedge where done is sampled high.
  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!done && n < 40);
    if (!done) begin
      total++; bad++;
      $display("FAIL wait_done: timeout after %0d cycles", n);
    end
  endtask

  // Monitor: compare each done pulse with the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done: done=1 at cycle %0d with no request pending", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dbz);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    logic [15:0] a, b;
    logic        sm;
    int          n;
    // Outputs while held in reset.
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset after 5 iterations abandons the operation.
    issue(16'd5000, 16'd3, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_back());
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_quot", quotient, 0);
    chk("midrst_rem", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Basic unsigned division, with busy timing.
    issue(16'd16785, 16'd3245, 1'b0);
    @(negedge clk);
    chk("busy_after_E0", busy, 1);
    repeat (15) @(negedge clk);
    chk("busy_after_E15", busy, 1);
    @(negedge clk);
    chk("busy_after_E16", busy, 0);
    chk("done_after_E16", done, 1);
    // Start held in DONE: the boundary quotients run back-to-back.
    issue(16'd65535, 16'd1, 1'b0);
    wait_done();
    issue(16'd40535, 16'd25000, 1'b0);
    wait_done();
    issue(16'd65535, 16'd65535, 1'b0);
    wait_done();
    issue(16'd7, 16'd9, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    chk("hold_quot", quotient, 0);
    chk("hold_rem", remainder, 7);

    // Divide by zero, then a normal divide clears the flag.
    issue(16'd1234, 16'd0, 1'b0);
    wait_done();
    @(negedge clk);
    chk("dbz_held", div_by_zero, 1);
    chk("dbz_busy_low", busy, 0);
    issue(16'd100, 16'd7, 1'b0);
    @(negedge clk);
    chk("dbz_cleared", div_by_zero, 0);
    wait_done();
    repeat (2) @(negedge clk);

    // A start during RUN is ignored; a second done would be spurious.
    issue(16'd30000, 16'd7, 1'b0);
    repeat (4) @(negedge clk);
    dividend = 16'd9; divisor = 16'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);

`ifdef SIGNED_DIV_EN
    issue(-16'sd7, 16'd2, 1'b1);
    wait_done();
    issue(16'd7, -16'sd2, 1'b1);
    wait_done();
    issue(16'h8000, 16'hFFFF, 1'b1);
    wait_done();
    issue(16'hFF00, 16'd0, 1'b1);
    wait_done();
    @(negedge clk);
`endif

    // Random operands, mixed idle gaps and back-to-back starts.
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1, 2:    b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
`ifdef SIGNED_DIV_EN
      sm = 1'($urandom);
`else
      sm = 1'b0;
`endif
      issue(a, b, sm);
      wait_done();
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Drain the scoreboard.
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d results still pending", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
